mips32_mem_arbiter: RTL and testbench
=====================================

// Module: mips32_mem_arbiter
// PURPOSE
//  Shares the single-port 1024x32 unified memory between the pipeline's instruction-fetch port (IF) and its data port (LW/SW, MEM stage).
//  One grant per cycle. Synchronous memory returns read data one cycle after grant, routed back to the owner.
//  Data port has fixed priority by default; a starvation counter guarantees fetch progress.
//  Honours pipeline halt and taken-branch flush.
// PARAMETERS
//  AW          10  memory word-address width (1024 words)
//  DW          32  data width
//  STARVE_MAX  4   consecutive denied IF cycles before IF is forced ahead of DM (1..15)
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  halt       in   1   pipeline HALTED; blocks new grants
//  if_flush   in   1   taken branch; squash in-flight IF response
//  if_req     in   1   fetch request; hold with if_addr until if_gnt
//  if_addr    in   AW  fetch word address (PC)
//  if_gnt     out  1   fetch accepted this cycle (combinational)
//  if_rvalid  out  1   fetch data valid
//  if_rdata   out  DW  fetched instruction
//  dm_req     in   1   data request; hold with dm_we/dm_addr/dm_wdata until dm_gnt
//  dm_we      in   1   1 = store (SW), 0 = load (LW)
//  dm_addr    in   AW  data word address (ALUOut)
//  dm_wdata   in   DW  store data
//  dm_gnt     out  1   data access accepted this cycle (combinational)
//  dm_rvalid  out  1   load data valid / store complete
//  dm_rdata   out  DW  load data (0 for stores)
//  mem_en     out  1   memory access strobe = if_gnt|dm_gnt
//  mem_we     out  1   dm_gnt & dm_we
//  mem_addr   out  AW  address of granted requester (0 when idle)
//  mem_wdata  out  DW  dm_wdata when store granted, else 0
//  mem_rdata  in   DW  memory read data, valid cycle after mem_en & ~mem_we
// BEHAVIOUR
//  - Reset: rsp_owner=NONE, starve_cnt=0, last_gnt=IF; if_rvalid=dm_rvalid=0, rdata outputs 0.
//    Reset mid-access drops any in-flight response.
//  - Grant (combinational, at most one):
//    - halt=1 -> no grant.
//    - Else if dm_req & ~(if_req & starve_cnt==STARVE_MAX) -> DM.
//    - Else if if_req -> IF.
//  - starve_cnt: +1 (saturating at STARVE_MAX) each cycle if_req & ~if_gnt & ~halt; cleared on if_gnt or ~if_req.
//  - Response FSM (rsp_owner): NONE -> IF on if_gnt, -> DM on dm_gnt, else NONE; re-evaluated every cycle,
//    so back-to-back grants give one response per cycle.
//  - Latency: exactly 1 cycle gnt -> rvalid.
//    - IF: if_rvalid=1, if_rdata=mem_rdata.
//    - DM load: dm_rvalid=1, dm_rdata=mem_rdata.
//    - DM store: dm_rvalid=1, dm_rdata=0; memory written on the grant edge.
//  - if_flush=1 in the grant cycle or the response cycle -> if_rvalid forced 0 for that fetch; a store never squashed.
//  - halt asserted while a response is pending: response still delivered next cycle.
//  - Simultaneous if_req & dm_req with starve_cnt<STARVE_MAX -> DM wins; IF waits, counter increments.
//  - Address is word index; no wrap logic (AW bits only, upper bits of source truncated by caller).
// CONFIGURATION
//  MIPS32_MEM_ARB_RR_EN defined: round-robin arbitration.
//    - On contention grant the requester not in last_gnt; last_gnt updates on every grant.
//    - starve_cnt logic removed (STARVE_MAX ignored).
//  Undefined: fixed DM priority with starvation override as above.
// TESTING
//  1. rst=1 2 cycles, reqs high -> no gnt, all outputs 0; after release IF-only req addr 5, mem[5]=0xDEADBEEF
//     -> if_gnt cyc0, if_rvalid+if_rdata=0xDEADBEEF cyc1.
//  2. if_req and dm_req (load addr 9) same cycle -> dm_gnt first, dm_rdata=mem[9] next cycle; if_gnt following cycle.
//  3. dm_req held high 10 cycles, if_req high, STARVE_MAX=4
//     -> if_gnt on 5th cycle, counter back to 0, DM resumes (RR build: strict alternation).
//  4. store dm_we=1 addr 3 data 0x12345678 -> mem_we=1 that cycle, dm_rvalid next cycle;
//     subsequent load addr 3 returns 0x12345678.
//  5. if_gnt addr 7 then if_flush=1 next cycle -> if_rvalid stays 0; new fetch addr 20 returns mem[20] normally.
//  6. halt=1 with pending IF response -> response delivered, no further gnt while halt=1;
//     rst mid-response -> rvalid 0 next cycle.

Source files
------------

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares the single-port 1024x32 unified memory between
// the instruction-fetch port (IF) and the data port (DM, LW/SW).
// At most one grant per cycle; read data returns one cycle after the grant
// and is routed back to whichever port owned the access.
// Build option: define MIPS32_MEM_ARB_RR_EN for round-robin arbitration;
// otherwise DM has fixed priority with a starvation override for IF.
module mips32_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt,
    input  logic          if_flush,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DM   = 2'd2
    } rsp_owner_t;

    rsp_owner_t rsp_owner;
    logic       rsp_squash;
    logic       rsp_store;
    logic       grant_if;
    logic       grant_dm;

`ifdef MIPS32_MEM_ARB_RR_EN
    typedef enum logic {
        LAST_IF = 1'b0,
        LAST_DM = 1'b1
    } last_gnt_t;

    last_gnt_t last_gnt;

    // Round-robin pick: on contention the port that was not granted last wins
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (!rst && !halt) begin
            if (dm_req && (!if_req || last_gnt == LAST_IF)) begin
                grant_dm = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // Remember which port received the most recent grant
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= LAST_IF;
        end else if (grant_dm) begin
            last_gnt <= LAST_DM;
        end else if (grant_if) begin
            last_gnt <= LAST_IF;
        end
    end
`else
    localparam int CW = 4;

    logic [CW-1:0] starve_cnt;
    logic          if_forced;

    assign if_forced = if_req && (starve_cnt == CW'(STARVE_MAX));

    // Fixed DM priority, except a starved fetch is pushed ahead of DM once
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (!rst && !halt) begin
            if (dm_req && !if_forced) begin
                grant_dm = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // Count consecutive cycles a waiting fetch was denied (halt cycles do not count)
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_if || !if_req) begin
            starve_cnt <= '0;
        end else if (!halt && starve_cnt != CW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // Response owner FSM: tracks who owns the data coming back next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_owner  <= RSP_NONE;
            rsp_squash <= 1'b0;
            rsp_store  <= 1'b0;
        end else begin
            rsp_squash <= if_flush;
            rsp_store  <= dm_we;
            if (grant_if) begin
                rsp_owner <= RSP_IF;
            end else if (grant_dm) begin
                rsp_owner <= RSP_DM;
            end else begin
                rsp_owner <= RSP_NONE;
            end
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;

    assign mem_en    = grant_if | grant_dm;
    assign mem_we    = grant_dm & dm_we;
    assign mem_addr  = grant_if ? if_addr : (grant_dm ? dm_addr : '0);
    assign mem_wdata = (grant_dm && dm_we) ? dm_wdata : '0;

    // A fetch is squashed by a flush seen in either its grant or its response cycle
    assign if_rvalid = !rst && (rsp_owner == RSP_IF) && !rsp_squash && !if_flush;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;

    assign dm_rvalid = !rst && (rsp_owner == RSP_DM);
    assign dm_rdata  = (dm_rvalid && !rsp_store) ? mem_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level reference of the arbitration rules.
// Honours MIPS32_MEM_ARB_RR_EN the same way the design does.
module tb_mips32_mem_arbiter;

    localparam int AW         = 10;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt;
    logic          if_flush;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: denied-fetch count, last granted port, response due this cycle
    int            ref_denied = 0;
    int            ref_last   = 1;
    int            cur_owner  = 0;
    logic [DW-1:0] cur_data   = '0;
    bit            cur_flushed = 1'b0;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .halt(halt), .if_flush(if_flush),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory model driven by the arbiter
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Which port should own the memory for the current inputs: 0 none, 1 IF, 2 DM
    function automatic int ref_pick();
        if (rst || halt) return 0;
        if (if_req && dm_req) begin
`ifdef MIPS32_MEM_ARB_RR_EN
            return (ref_last == 1) ? 2 : 1;
`else
            return (ref_denied >= STARVE_MAX) ? 1 : 2;
`endif
        end
        if (dm_req) return 2;
        if (if_req) return 1;
        return 0;
    endfunction

    // Advance the reference on each clock edge
    always @(posedge clk) begin
        int g;
        g = ref_pick();
        if (rst) begin
            ref_denied <= 0;
            ref_last   <= 1;
            cur_owner  <= 0;
        end else begin
            if (!if_req || g == 1)  ref_denied <= 0;
            else if (!halt)         ref_denied <= (ref_denied + 1 > STARVE_MAX) ? STARVE_MAX : ref_denied + 1;
            if (g != 0) ref_last <= g;
            cur_owner   <= g;
            cur_data    <= (g == 1) ? mem[if_addr] : ((g == 2 && !dm_we) ? mem[dm_addr] : '0);
            cur_flushed <= if_flush;
        end
    end

    // Apply one cycle of inputs at the falling edge, then let outputs settle
    task automatic drive(input bit r, input bit h, input bit fl,
                         input bit ir, input logic [AW-1:0] ia,
                         input bit dr, input bit dw, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd);
        @(negedge clk);
        rst = r; halt = h; if_flush = fl;
        if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = wd;
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 0, 1, 10'd5, 1, 0, 10'd9, 32'h0);
            n_checks++;
            if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b0000) begin
                n_errors++;
                $display("[TB] FAIL reset_grants: got %b expected 0000", {if_gnt, dm_gnt, mem_en, mem_we});
            end
            n_checks++;
            if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata, mem_addr, mem_wdata} !== '0) begin
                n_errors++;
                $display("[TB] FAIL reset_outputs: rv=%b%b ird=%h drd=%h addr=%0d wd=%h expected all 0",
                         if_rvalid, dm_rvalid, if_rdata, dm_rdata, mem_addr, mem_wdata);
            end
        end
        drive(0, 0, 0, 1, 10'd5, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if ({if_gnt, dm_gnt, mem_en} !== 3'b101 || mem_addr !== 10'd5) begin
            n_errors++;
            $display("[TB] FAIL first_fetch_gnt: gnt=%b%b addr=%0d expected 10 addr 5", if_gnt, dm_gnt, mem_addr);
        end
        drive(0, 0, 0, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("[TB] FAIL first_fetch_data: rvalid=%b data=%h expected 1 deadbeef", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] exp9, exp11;
        exp9  = mem[9];
        exp11 = mem[11];
        drive(0, 0, 0, 1, 10'd11, 1, 0, 10'd9, 32'h0);
        n_checks++;
        if ({if_gnt, dm_gnt} !== 2'b01 || mem_addr !== 10'd9) begin
            n_errors++;
            $display("[TB] FAIL contention_dm_first: gnt=%b%b addr=%0d expected 01 addr 9", if_gnt, dm_gnt, mem_addr);
        end
        drive(0, 0, 0, 1, 10'd11, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if ({if_gnt, dm_gnt} !== 2'b10 || dm_rvalid !== 1'b1 || dm_rdata !== exp9) begin
            n_errors++;
            $display("[TB] FAIL contention_if_next: gnt=%b%b dm_rvalid=%b dm_rdata=%h expected 10 1 %h",
                     if_gnt, dm_gnt, dm_rvalid, dm_rdata, exp9);
        end
        drive(0, 0, 0, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== exp11 || dm_rvalid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL contention_if_data: rvalid=%b data=%h dm_rvalid=%b expected 1 %h 0",
                     if_rvalid, if_rdata, dm_rvalid, exp11);
        end
    endtask

    task automatic test_starvation();
        logic [1:0] want;
        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, 0, 1, 10'(40 + k), 1, 0, 10'(30 + k), 32'h0);
`ifdef MIPS32_MEM_ARB_RR_EN
            want = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            want = (k % (STARVE_MAX + 1) == 0) ? 2'b10 : 2'b01;
`endif
            n_checks++;
            if ({if_gnt, dm_gnt} !== want) begin
                n_errors++;
                $display("[TB] FAIL starvation_cycle%0d: gnt=%b%b expected %b", k, if_gnt, dm_gnt, want);
            end
        end
        drive(0, 0, 0, 0, 10'd0, 0, 0, 10'd0, 32'h0);
    endtask

    task automatic test_store();
        drive(0, 0, 0, 0, 10'd0, 1, 1, 10'd3, 32'h12345678);
        n_checks++;
        if ({dm_gnt, mem_we} !== 2'b11 || mem_addr !== 10'd3 || mem_wdata !== 32'h12345678) begin
            n_errors++;
            $display("[TB] FAIL store_grant: gnt=%b we=%b addr=%0d wd=%h expected 1 1 3 12345678",
                     dm_gnt, mem_we, mem_addr, mem_wdata);
        end
        drive(0, 0, 0, 0, 10'd0, 1, 0, 10'd3, 32'h0);
        n_checks++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h0 || dm_gnt !== 1'b1 || mem_we !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL store_complete: rvalid=%b rdata=%h gnt=%b we=%b expected 1 0 1 0",
                     dm_rvalid, dm_rdata, dm_gnt, mem_we);
        end
        drive(0, 0, 0, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h12345678) begin
            n_errors++;
            $display("[TB] FAIL store_readback: rvalid=%b rdata=%h expected 1 12345678", dm_rvalid, dm_rdata);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] exp20;
        exp20 = mem[20];
        drive(0, 0, 0, 1, 10'd7, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if (if_gnt !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL flush_gnt7: if_gnt=%b expected 1", if_gnt);
        end
        drive(0, 0, 1, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if (if_rvalid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL flush_rsp_cycle: if_rvalid=%b expected 0", if_rvalid);
        end
        drive(0, 0, 1, 1, 10'd7, 0, 0, 10'd0, 32'h0);
        drive(0, 0, 0, 1, 10'd20, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if (if_rvalid !== 1'b0 || if_gnt !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL flush_gnt_cycle: if_rvalid=%b if_gnt=%b expected 0 1", if_rvalid, if_gnt);
        end
        drive(0, 0, 0, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== exp20) begin
            n_errors++;
            $display("[TB] FAIL flush_refetch: rvalid=%b data=%h expected 1 %h", if_rvalid, if_rdata, exp20);
        end
    endtask

    task automatic test_halt_and_reset();
        logic [DW-1:0] exp50;
        exp50 = mem[50];
        drive(0, 0, 0, 1, 10'd50, 0, 0, 10'd0, 32'h0);
        drive(0, 1, 0, 1, 10'd51, 1, 0, 10'd60, 32'h0);
        n_checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== exp50 || {if_gnt, dm_gnt, mem_en} !== 3'b000) begin
            n_errors++;
            $display("[TB] FAIL halt_pending_rsp: rvalid=%b data=%h gnt=%b%b en=%b expected 1 %h 00 0",
                     if_rvalid, if_rdata, if_gnt, dm_gnt, mem_en, exp50);
        end
        drive(0, 1, 0, 1, 10'd51, 1, 0, 10'd60, 32'h0);
        n_checks++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0000) begin
            n_errors++;
            $display("[TB] FAIL halt_no_grant: gnt=%b%b rv=%b%b expected 0000", if_gnt, dm_gnt, if_rvalid, dm_rvalid);
        end
        drive(0, 0, 0, 1, 10'd51, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if (if_gnt !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL halt_release: if_gnt=%b expected 1", if_gnt);
        end
        drive(1, 0, 0, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        drive(0, 0, 0, 0, 10'd0, 0, 0, 10'd0, 32'h0);
        n_checks++;
        if ({if_rvalid, dm_rvalid} !== 2'b00) begin
            n_errors++;
            $display("[TB] FAIL reset_drops_rsp: rv=%b%b expected 00", if_rvalid, dm_rvalid);
        end
    endtask

    task automatic test_random();
        bit            ih = 0, dh = 0, r, h, fl, dw;
        logic [AW-1:0] ia = '0, da = '0;
        logic [DW-1:0] wd = '0;
        int            g;
        logic [AW-1:0] exp_addr;
        for (int n = 0; n < 400; n++) begin
            if (!ih && $urandom_range(0, 2) != 0) begin ih = 1; ia = AW'($urandom); end
            if (!dh && $urandom_range(0, 2) != 0) begin
                dh = 1; da = AW'($urandom); dw = ($urandom_range(0, 3) == 0); wd = $urandom;
            end
            r  = ($urandom_range(0, 59) == 0);
            h  = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 5) == 0);
            drive(r, h, fl, ih, ia, dh, dw, da, wd);
            g = ref_pick();
            exp_addr = (g == 1) ? ia : ((g == 2) ? da : '0);
            n_checks++;
            if ({if_gnt, dm_gnt} !== {g == 1, g == 2}) begin
                n_errors++;
                $display("[TB] FAIL rand_grant@%0d: gnt=%b%b expected %b%b", n, if_gnt, dm_gnt, g == 1, g == 2);
            end
            n_checks++;
            if (mem_en !== (g != 0) || mem_we !== (g == 2 && dw) || mem_addr !== exp_addr ||
                mem_wdata !== ((g == 2 && dw) ? wd : '0)) begin
                n_errors++;
                $display("[TB] FAIL rand_membus@%0d: en=%b we=%b addr=%0d wd=%h expected addr %0d",
                         n, mem_en, mem_we, mem_addr, mem_wdata, exp_addr);
            end
            n_checks++;
            if (if_rvalid !== (!r && cur_owner == 1 && !cur_flushed && !fl) ||
                dm_rvalid !== (!r && cur_owner == 2)) begin
                n_errors++;
                $display("[TB] FAIL rand_rvalid@%0d: rv=%b%b owner=%0d", n, if_rvalid, dm_rvalid, cur_owner);
            end
            if (if_rvalid === 1'b1 && if_rdata !== cur_data) begin
                n_errors++;
                $display("[TB] FAIL rand_if_rdata@%0d: got %h expected %h", n, if_rdata, cur_data);
            end
            if (dm_rvalid === 1'b1 && dm_rdata !== cur_data) begin
                n_errors++;
                $display("[TB] FAIL rand_dm_rdata@%0d: got %h expected %h", n, dm_rdata, cur_data);
            end
            if (g == 1) ih = 0;
            if (g == 2) dh = 0;
        end
        drive(0, 0, 0, 0, 10'd0, 0, 0, 10'd0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[5] = 32'hDEADBEEF;
        rst = 1'b1; halt = 1'b0; if_flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        test_reset();
        test_contention();
        test_starvation();
        test_store();
        test_flush();
        test_halt_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
